// File: rtl/pipe_ctrl.sv
// Pipeline hazard / multi-cycle controller.
// Detects load-use hazards between ID sources and an EX load, freezes the
// pipe for multi-cycle EX ops, and arbitrates flushes over both.

// One ID source operand compared against the EX destination.
module pipe_ctrl_src_cmp #(
  parameter int REG_W = 5
) (
  input  logic             rd,
  input  logic [REG_W-1:0] addr,
  input  logic [REG_W-1:0] ex_wd,
  output logic             hit
);
  assign hit = rd & (addr == ex_wd);
endmodule

module pipe_ctrl #(
  parameter int REG_W   = 5,
  parameter int LEN_W   = 6,
  parameter int CNT_W   = 16,
  parameter int NUM_SRC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_reg1_read,
  input  logic             id_reg2_read,
  input  logic [REG_W-1:0] id_reg1_addr,
  input  logic [REG_W-1:0] id_reg2_addr,
  input  logic             ex_wreg,
  input  logic [REG_W-1:0] ex_wd,
  input  logic             ex_is_load,
  input  logic             mc_start,
  input  logic [LEN_W-1:0] mc_len,
  input  logic             flush_req,
  output logic [5:0]       stall,
  output logic             flush_o,
  output logic             mc_done_o,
  output logic             mc_abort_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN = 1'b0, MC = 1'b1} state_t;

  typedef struct packed {
    logic             start;
    logic [LEN_W-1:0] len;
  } mc_req_t;

  localparam logic [5:0] STALL_MC   = 6'b001111;
  localparam logic [5:0] STALL_LU   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  state_t                         state;
  logic [LEN_W-1:0]               cnt;
  logic [NUM_SRC-1:0]             src_rd;
  logic [NUM_SRC-1:0][REG_W-1:0]  src_addr;
  logic [NUM_SRC-1:0]             src_hit;
  logic                           load_use;
  logic                           mc_go;
  mc_req_t                        mc_req;

  assign src_rd   = {id_reg2_read, id_reg1_read};
  assign src_addr = {id_reg2_addr, id_reg1_addr};
  assign mc_req   = '{start: mc_start, len: mc_len};

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_src
      pipe_ctrl_src_cmp #(.REG_W(REG_W)) u_cmp (
        .rd   (src_rd[g]),
        .addr (src_addr[g]),
        .ex_wd(ex_wd),
        .hit  (src_hit[g])
      );
    end
  endgenerate

  // Hazard only when EX load actually writes a non-zero register an ID source reads.
  assign load_use = ex_is_load & ex_wreg & (ex_wd != '0) & (|src_hit);

  // Lengths 0/1 complete in EX's single cycle, so they never enter MC.
  assign mc_go = mc_req.start & (mc_req.len >= LEN_W'(2));

  // Hold vector: flush wins, then MC freeze, then load-use bubble.
  always_comb begin
    stall = STALL_NONE;
    if (flush_req)         stall = STALL_NONE;
    else if (state == MC)  stall = STALL_MC;
    else if (load_use)     stall = STALL_LU;
  end

  assign busy_o = (state == MC);

  // FSM, MC countdown and registered event pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      cnt        <= '0;
      flush_o    <= 1'b0;
      mc_done_o  <= 1'b0;
      mc_abort_o <= 1'b0;
    end else begin
      flush_o    <= flush_req;
      mc_abort_o <= flush_req & (state == MC);
      mc_done_o  <= 1'b0;
      if (flush_req) begin
        state <= RUN;
        cnt   <= '0;
      end else begin
        case (state)
          RUN: if (mc_go) begin
            // The mc_start cycle is EX cycle 1; MC covers the remaining len-1.
            cnt   <= mc_req.len - LEN_W'(2);
            state <= MC;
          end
          MC: if (cnt == '0) begin
            state     <= RUN;
            mc_done_o <= 1'b1;
          end else begin
            cnt <= cnt - LEN_W'(1);
          end
          default: state <= RUN;
        endcase
      end
    end
  end

  // Saturating count of cycles where the PC was held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               stall_cnt <= '0;
    else if (stall[0] && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: inputs change on the falling edge,
// combinational outputs are checked 1 time unit later, registered outputs
// are checked at the following falling edge.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_reg1_read = 0, id_reg2_read = 0;
  logic [4:0] id_reg1_addr = 0, id_reg2_addr = 0;
  logic       ex_wreg = 0, ex_is_load = 0;
  logic [4:0] ex_wd = 0;
  logic       mc_start = 0;
  logic [5:0] mc_len = 0;
  logic       flush_req = 0;
  logic [5:0] stall;
  logic       flush_o, mc_done_o, mc_abort_o, busy_o;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .id_reg1_read(id_reg1_read), .id_reg2_read(id_reg2_read),
    .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr),
    .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_is_load(ex_is_load),
    .mc_start(mc_start), .mc_len(mc_len), .flush_req(flush_req),
    .stall(stall), .flush_o(flush_o), .mc_done_o(mc_done_o),
    .mc_abort_o(mc_abort_o), .busy_o(busy_o), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr;
    id_reg1_read = 0; id_reg2_read = 0; id_reg1_addr = 0; id_reg2_addr = 0;
    ex_wreg = 0; ex_is_load = 0; ex_wd = 0;
    mc_start = 0; mc_len = 0; flush_req = 0;
  endtask

  task automatic set_lu2;
    ex_is_load = 1; ex_wreg = 1; ex_wd = 5; id_reg2_read = 1; id_reg2_addr = 5;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_done", mc_done_o, 0);
    chk("rst_abort", mc_abort_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_cnt", stall_cnt, 0);
    @(negedge clk); rst = 1;

    // Load-use via source 2
    @(negedge clk); set_lu2; #1;
    chk("lu2_stall", stall, 32'h07);
    @(negedge clk);
    chk("lu2_cnt", stall_cnt, 1);
    ex_wd = 0; #1;
    chk("lu_r0_stall", stall, 0);
    @(negedge clk);
    chk("lu_r0_cnt", stall_cnt, 1);
    // Load-use via source 1
    ex_wd = 7; id_reg1_read = 1; id_reg1_addr = 7; id_reg2_read = 0; #1;
    chk("lu1_stall", stall, 32'h07);
    @(negedge clk);
    chk("lu1_cnt", stall_cnt, 2);
    id_reg1_read = 0; #1;
    chk("lu1_noread", stall, 0);
    @(negedge clk); clr;

    // Multi-cycle op, len 4 -> 3 MC cycles
    mc_start = 1; mc_len = 4; #1;
    chk("mc4_c0_stall", stall, 0);
    chk("mc4_c0_busy", busy_o, 0);
    @(negedge clk); mc_start = 0;
    chk("mc4_c1_busy", busy_o, 1);
    #1 chk("mc4_c1_stall", stall, 32'h0F);
    @(negedge clk);
    mc_start = 1; mc_len = 4;          // ignored while in MC
    #1 chk("mc4_c2_stall", stall, 32'h0F);
    chk("mc4_c2_busy", busy_o, 1);
    @(negedge clk); clr; set_lu2;      // load-use ignored while in MC
    #1 chk("mc4_c3_stall", stall, 32'h0F);
    chk("mc4_c3_done", mc_done_o, 0);
    @(negedge clk);
    chk("mc4_done", mc_done_o, 1);
    chk("mc4_busy_end", busy_o, 0);
    chk("mc4_cnt", stall_cnt, 5);
    clr; #1;
    chk("mc4_stall_end", stall, 0);
    @(negedge clk);
    chk("mc4_done_once", mc_done_o, 0);
    chk("mc4_busy_after", busy_o, 0);

    // Degenerate lengths 1 and 0
    mc_start = 1; mc_len = 1; #1;
    chk("len1_stall", stall, 0);
    @(negedge clk);
    chk("len1_busy", busy_o, 0);
    chk("len1_done", mc_done_o, 0);
    mc_len = 0; #1;
    chk("len0_stall", stall, 0);
    @(negedge clk);
    chk("len0_busy", busy_o, 0);
    chk("len0_done", mc_done_o, 0);
    chk("len0_stall2", stall, 0);
    // len 2 -> exactly one MC cycle
    mc_len = 2;
    @(negedge clk); clr;
    chk("len2_busy", busy_o, 1);
    #1 chk("len2_stall", stall, 32'h0F);
    @(negedge clk);
    chk("len2_done", mc_done_o, 1);
    chk("len2_busy_end", busy_o, 0);
    chk("len2_cnt", stall_cnt, 6);

    // Flush abort on third MC cycle of a len-10 op
    @(negedge clk); mc_start = 1; mc_len = 10;
    @(negedge clk); clr;
    @(negedge clk);
    @(negedge clk); flush_req = 1; #1;
    chk("abort_stall", stall, 0);
    chk("abort_busy_pre", busy_o, 1);
    @(negedge clk); flush_req = 0;
    chk("abort_flush", flush_o, 1);
    chk("abort_abort", mc_abort_o, 1);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", mc_done_o, 0);
    chk("abort_cnt", stall_cnt, 8);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_no_done", mc_done_o, 0);
    end
    chk("abort_flush_clr", flush_o, 0);

    // Flush in RUN beats mc_start and load-use
    set_lu2; flush_req = 1; mc_start = 1; mc_len = 4; #1;
    chk("fr_stall", stall, 0);
    @(negedge clk); clr;
    chk("fr_flush", flush_o, 1);
    chk("fr_abort", mc_abort_o, 0);
    chk("fr_busy", busy_o, 0);
    @(negedge clk);
    chk("fr_flush_pulse", flush_o, 0);
    chk("fr_busy2", busy_o, 0);

    // Load-use coinciding with mc_start (len 3)
    set_lu2; mc_start = 1; mc_len = 3; #1;
    chk("co_stall_lu", stall, 32'h07);
    @(negedge clk); clr;
    chk("co_busy1", busy_o, 1);
    #1 chk("co_stall_mc", stall, 32'h0F);
    @(negedge clk);
    chk("co_busy2", busy_o, 1);
    @(negedge clk);
    chk("co_done", mc_done_o, 1);
    chk("co_cnt", stall_cnt, 11);

    // Async reset between edges mid-MC
    @(negedge clk); mc_start = 1; mc_len = 10;
    @(negedge clk); clr;
    @(posedge clk); #2 rst = 0; #1;
    chk("ar_busy", busy_o, 0);
    chk("ar_stall", stall, 0);
    chk("ar_cnt", stall_cnt, 0);
    chk("ar_flush", flush_o, 0);
    chk("ar_done", mc_done_o, 0);
    chk("ar_abort", mc_abort_o, 0);
    @(negedge clk); rst = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("ar_post_pulse", {busy_o, mc_done_o, mc_abort_o}, 0);
    end

    // Saturation of stall_cnt
    set_lu2;
    repeat (65534) @(negedge clk);
    chk("sat_fffe", stall_cnt, 16'hFFFE);
    @(negedge clk);
    chk("sat_ffff", stall_cnt, 16'hFFFF);
    repeat (4465) @(negedge clk);
    chk("sat_hold", stall_cnt, 16'hFFFF);
    clr;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL expose clk  input  1  rising-edge clock for all state.
REQ-002 SHALL expose rst  input  1  reset; one clock, reset asynchronous and active-low (rst=0 resets).
REQ-003 SHALL expose id_reg1_read, id_reg2_read  input  1 each  ID stage source-read enables.
REQ-004 SHALL expose id_reg1_addr, id_reg2_addr  input  5 each  ID stage source register addresses.
REQ-005 SHALL expose ex_wreg  input  1  EX write-enable; ex_wd  input  5  EX destination; ex_is_load  input  1  EX holds a load.
REQ-006 SHALL expose mc_start  input  1  EX begins multi-cycle op; mc_len  input  6  total EX cycles of that op.
REQ-007 SHALL expose flush_req  input  1  exception/redirect request.
REQ-008 SHALL expose stall  output  6  hold vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (0).
REQ-009 SHALL expose flush_o  output  1  registered one-cycle flush pulse.
REQ-010 SHALL expose mc_done_o, mc_abort_o  output  1 each  registered one-cycle pulses.
REQ-011 SHALL expose busy_o  output  1  high while in MC state.
REQ-012 SHALL expose stall_cnt  output  16  saturating count of cycles with stall[0]=1.

Function
REQ-013 SHALL implement states RUN and MC; reset state RUN.
REQ-014 SHALL compute load_use = ex_is_load & ex_wreg & (ex_wd!=0) & ((id_reg1_read & id_reg1_addr==ex_wd) | (id_reg2_read & id_reg2_addr==ex_wd)), combinationally.
REQ-015 SHALL drive stall combinationally: MC -> 6'b001111; RUN with load_use -> 6'b000111; otherwise 6'b000000.
REQ-016 SHALL force stall=0 in any cycle where flush_req=1, regardless of state.
REQ-017 In RUN, mc_start=1 with mc_len>=2 and flush_req=0 SHALL load counter with mc_len-2 and enter MC next cycle.
REQ-018 mc_start with mc_len of 0 or 1 SHALL be treated as single-cycle: no state change, no stall, no mc_done_o.
REQ-019 In MC, counter SHALL decrement each cycle; when counter=0, next state RUN and mc_done_o=1 for exactly that next cycle.
REQ-020 Op of mc_len=N SHALL produce exactly N-1 cycles of stall=6'b001111 starting the cycle after mc_start.
REQ-021 mc_start asserted while in MC SHALL be ignored.
REQ-022 load_use SHALL be ignored while in MC (pipeline frozen).
REQ-023 If mc_start and load_use coincide in RUN, load-use stall SHALL apply that cycle and the MC entry SHALL still occur.
REQ-024 flush_req=1 SHALL have highest priority: next state RUN, counter cleared, flush_o=1 next cycle.
REQ-025 flush_req=1 in MC SHALL also pulse mc_abort_o next cycle and suppress mc_done_o.
REQ-026 flush_req and mc_start in same RUN cycle SHALL ignore mc_start.
REQ-027 stall_cnt SHALL increment on each clock where stall[0]=1 and hold at 16'hFFFF.
REQ-028 busy_o SHALL equal (state==MC).

Reset
REQ-029 rst=0 SHALL immediately force state RUN, counter 0, flush_o 0, mc_done_o 0, mc_abort_o 0, stall_cnt 0, hence stall 0 and busy_o 0.
REQ-030 rst asserted mid-MC SHALL abandon the op without any mc_done_o or mc_abort_o pulse.
REQ-031 After rst release, first rising edge SHALL evaluate inputs normally.

Verification
REQ-032 Load-use: ex_is_load=1, ex_wreg=1, ex_wd=5, id_reg2_read=1, id_reg2_addr=5 -> stall=6'b000111 same cycle; ex_wd=0 same setup -> stall=0.
REQ-033 Multi-cycle: mc_start=1, mc_len=4 in RUN -> stall=6'b001111 and busy_o=1 for 3 cycles, then RUN, mc_done_o=1 one cycle, stall_cnt=3.
REQ-034 Degenerate length: mc_start=1 with mc_len=1, then mc_len=0 -> stall stays 0, no mc_done_o, busy_o=0.
REQ-035 Flush abort: mc_len=10, flush_req=1 on third MC cycle -> stall=0 that cycle, next cycle flush_o=1, mc_abort_o=1, busy_o=0, no mc_done_o thereafter.
REQ-036 Saturation: hold load_use for 70000 cycles -> stall_cnt=16'hFFFF, no wrap.
REQ-037 Async reset: drop rst between clock edges mid-MC -> all outputs 0 before next edge; no pulse after release.
